// File: rtl/seq_multiplier_param_if.sv
// seq_multiplier_param_if: start/busy/done handshake and operand/product bus for the multiplier
interface seq_multiplier_param_if #(parameter int WIDTH = 32);
    logic               start;
    logic               signed_mode;
    logic [WIDTH-1:0]   dataA;
    logic [WIDTH-1:0]   dataB;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] dataOut;
    modport master (output start, signed_mode, dataA, dataB, input busy, done, dataOut);
    modport slave (input start, signed_mode, dataA, dataB, output busy, done, dataOut);
endinterface

// File: rtl/seq_multiplier_param.sv
// seq_multiplier_param: shift-add multiplier on operand magnitudes, sign reapplied at the end
module seq_multiplier_param #(
    parameter int WIDTH      = 32,
    parameter int EARLY_EXIT = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    seq_multiplier_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] acc, mcand, sum, dout;
    logic [WIDTH-1:0]   mplier, mshift, mag_a, mag_b;
    logic [CW-1:0]      cnt;
    logic               sign, accept, last;
    always_comb begin
        accept  = bus.start && state != RUN;
        mag_a   = (bus.signed_mode && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
        mag_b   = (bus.signed_mode && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;
        sum     = mplier[0] ? acc + mcand : acc;
        mshift  = mplier >> 1;
        last    = cnt == CW'(WIDTH - 1) || (EARLY_EXIT != 0 && mshift == '0);
        state_n = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            sign   <= 1'b0;
            dout   <= '0;
        end else begin
            state <= state_n;
            if (accept) begin
                sign   <= bus.signed_mode & (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
                mcand  <= {{WIDTH{1'b0}}, mag_a};
                mplier <= mag_b;
                acc    <= '0;
                cnt    <= '0;
            end else if (state == RUN) begin
                acc    <= sum;
                mcand  <= mcand << 1;
                mplier <= mshift;
                cnt    <= cnt + CW'(1);
                if (last)
                    dout <= sign ? -sum : sum;
            end
        end
    end
    assign bus.busy    = state == RUN;
    assign bus.done    = state == DONE;
    assign bus.dataOut = dout;
endmodule

// File: doc/seq_multiplier_param.md
Name: seq_multiplier_param

Overview:
- Parametrised sequential shift-add multiplier; successor to the fixed 32-bit unsigned multiplier in the ALU datapath.
- Adds generic operand width, signed/unsigned mode and optional early termination.
- Adds an explicit start/busy/done handshake, so the ALU controller no longer infers completion from a cycle count.
- Sits beside the ALU; the controller issues start and samples dataOut on done.

Parameters:
- WIDTH, 32: operand width in bits (>= 4); product is 2*WIDTH bits.
- EARLY_EXIT, 0: 1 = finish as soon as the remaining multiplier bits are all zero; 0 = always WIDTH iterations.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only when ready to accept.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
- dataA  input  WIDTH  multiplicand; sampled with start.
- dataB  input  WIDTH  multiplier; sampled with start.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse; result valid.
- dataOut  output  2*WIDTH  product; held until the next accepted start.

Behaviour:
- Reset is synchronous and active-low. On any edge with reset=0: state=IDLE, busy=0, done=0, dataOut=0, internal registers cleared. This applies mid-operation too; the partial result is discarded.
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: done=1 for exactly one cycle.
- Acceptance:
  - start=1 is accepted in IDLE or DONE (back-to-back operation).
  - start=1 in RUN is ignored; no queuing.
  - busy=1 exactly while in RUN.
- Capture edge (edge 0), on accept:
  - Latch sign = signed_mode & (dataA[MSB] ^ dataB[MSB]).
  - Latch mcand = |dataA| and mplier = |dataB|. Magnitudes are taken only when signed_mode=1, otherwise operands are used raw.
  - Magnitudes are WIDTH-bit unsigned; the most-negative value maps to 2^(WIDTH-1) without overflow.
  - Accumulator (2*WIDTH bits) cleared; iteration count=0; state→RUN.
  - dataOut unchanged.
- Each RUN edge:
  - If mplier[0]=1: acc += mcand, with mcand zero-extended and shifted to its current position. Held in a 2*WIDTH register shifted left one per iteration.
  - Then mplier >>= 1 (logical) and count++.
- Termination:
  - Normal: after iteration WIDTH (edge WIDTH).
  - EARLY_EXIT=1: at the first edge where the post-shift mplier == 0. dataB=0 finishes at edge 1; WIDTH iterations is the maximum.
- On the terminating edge:
  - dataOut ← sign ? -acc_final : acc_final, where acc_final includes this edge's add. Arithmetic is modulo 2^(2*WIDTH).
  - State→DONE.
  - Latency: done is high in the cycle after edge N, where N = iteration count (WIDTH when EARLY_EXIT=0).
- DONE to next state:
  - Next edge goes to IDLE, or to RUN if start=1 (new capture on that edge).
  - done never stays high for two consecutive cycles unless a new operation completes.
- Overflow: none possible; the full 2*WIDTH product is always exact.
- Simultaneous events: reset=0 has priority over start. start in DONE takes effect and done still drops on that edge.

Test Plan:
- WIDTH=32, unsigned, A=0x0000_FFFF, B=0x0001_0000, start for one cycle → busy 32 cycles; done pulse once; dataOut=0x0000_0000_FFFF_0000.
- WIDTH=32, unsigned, A=B=0xFFFF_FFFF → dataOut=0xFFFF_FFFE_0000_0001; done exactly 32 cycles after the capture edge.
- WIDTH=8, signed, A=0x80 (-128), B=0x80 → 0x4000. Also A=0xFD (-3), B=0x05 → 0xFFF1 (-15). Also A=0x7F, B=0xFF (-1) → 0xFF81.
- WIDTH=16, EARLY_EXIT=1, A=0x1234, B=0x0003 → done after 2 iterations, dataOut=0x0000_369C. B=0 → done after 1 iteration, dataOut=0.
- WIDTH=32, start A=7, B=6; pulse start again (A=1, B=1) at iteration 10 → second start ignored, dataOut=42. Then start in the DONE cycle with A=3, B=3 → busy next cycle; dataOut=9 on the second done.
- Mid-RUN reset=0 for one edge (A=5, B=5, after 4 iterations) → IDLE, busy=0, done=0, dataOut=0; no done pulse follows. A later start gives a correct product.
